// File: rtl/dvs_ravens_receiver.sv
// -----------------------------------------------------------------------------
// dvs_ravens_receiver
//   Decodes RAVENS packets (START / RUN / SPIKE) for a DVS front end. It keeps
//   the current timestep of a sim time and buffers decoded spikes, each tagged
//   with the timestep it arrived in, in a small registered FIFO.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   pkt_valid       ravens_pkt carries a packet this cycle
//   ravens_pkt      {opcode[2:0], payload}
//   pkt_rdy         packet accepted when pkt_valid && pkt_rdy (low when FIFO full)
//   spike_valid     FIFO head holds a decoded spike
//   spike_rdy       consumer pops the head when spike_valid && spike_rdy
//   spike_payload   payload of the head spike (0 when empty)
//   spike_timestep  timestep the head spike arrived in (0 when empty)
//   sim_time_done   one-cycle pulse when a RUN completes the sim time
//   timestep        current timestep
//   err_cnt         saturating error count (only with DVS_RAVENS_RX_ERR_CNT_EN)
//
// Build option
//   DVS_RAVENS_RX_ERR_CNT_EN : adds err_cnt, counting accepted illegal opcodes
//                              and SPIKE/RUN packets accepted in WAIT_START.
//
// FSM states
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   WAIT_START | idle between sim times; SPIKE and RUN are dropped
//   IN_SIM     | sim time running; SPIKEs are buffered, RUN advances timestep
// -----------------------------------------------------------------------------
module dvs_ravens_receiver #(
  parameter int SIM_TIME        = 15,
  parameter int FIFO_DEPTH      = 4,
  parameter int RAVENS_PKT_BITS = 11,
  parameter int TS_BITS         = $clog2(SIM_TIME + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pkt_valid,
  input  logic [RAVENS_PKT_BITS-1:0] ravens_pkt,
  output logic                       pkt_rdy,
  output logic                       spike_valid,
  input  logic                       spike_rdy,
  output logic [RAVENS_PKT_BITS-4:0] spike_payload,
  output logic [TS_BITS-1:0]         spike_timestep,
  output logic                       sim_time_done,
`ifdef DVS_RAVENS_RX_ERR_CNT_EN
  output logic [7:0]                 err_cnt,
`endif
  output logic [TS_BITS-1:0]         timestep
);

  localparam int PW    = RAVENS_PKT_BITS - 3;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // One bit wider than the wider operand so timestep + n never wraps.
  localparam int SUM_W = ((PW > TS_BITS) ? PW : TS_BITS) + 1;

  localparam logic [2:0] OP_SPIKE = 3'b000;
  localparam logic [2:0] OP_RUN   = 3'b001;
  localparam logic [2:0] OP_START = 3'b010;

  typedef enum logic {
    WAIT_START = 1'b0,
    IN_SIM     = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [TS_BITS-1:0] ts_nxt;
  logic               done_nxt;
  logic               push;
  logic               pop;
  logic               accept;

  logic [2:0]         opcode;
  logic [PW-1:0]      payload;
  logic [SUM_W-1:0]   run_n;
  logic [SUM_W-1:0]   run_sum;

  logic [PW-1:0]      pay_mem [FIFO_DEPTH];
  logic [TS_BITS-1:0] ts_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;

  assign opcode  = ravens_pkt[RAVENS_PKT_BITS-1 -: 3];
  assign payload = ravens_pkt[PW-1:0];
  assign accept  = pkt_valid && pkt_rdy;
  assign pop     = spike_valid && spike_rdy;

  // A RUN of 0 still advances one timestep.
  assign run_n   = (payload == '0) ? SUM_W'(1) : SUM_W'(payload);
  assign run_sum = SUM_W'(timestep) + run_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_START;
      timestep      <= '0;
      sim_time_done <= 1'b0;
    end else begin
      state         <= state_nxt;
      timestep      <= ts_nxt;
      sim_time_done <= done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ts_nxt    = timestep;
    done_nxt  = 1'b0;
    push      = 1'b0;
    if (accept) begin
      case (opcode)
        OP_START: begin
          state_nxt = IN_SIM;
          ts_nxt    = '0;
        end
        OP_SPIKE: begin
          push = (state == IN_SIM);
        end
        OP_RUN: begin
          if (state == IN_SIM) begin
            if (run_sum >= SUM_W'(SIM_TIME)) begin
              state_nxt = WAIT_START;
              ts_nxt    = '0;
              done_nxt  = 1'b1;
            end else begin
              ts_nxt = run_sum[TS_BITS-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs, all derived from registered state only
  always_comb begin
    pkt_rdy        = (fifo_cnt != CNT_W'(FIFO_DEPTH));
    spike_valid    = (fifo_cnt != '0);
    spike_payload  = '0;
    spike_timestep = '0;
    if (spike_valid) begin
      spike_payload  = pay_mem[rd_ptr];
      spike_timestep = ts_mem[rd_ptr];
    end
  end

  // FIFO control; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pay_mem[wr_ptr] <= payload;
      ts_mem[wr_ptr]  <= timestep;
    end
  end

`ifdef DVS_RAVENS_RX_ERR_CNT_EN
  logic err_evt;

  assign err_evt = accept &&
                   ((opcode > OP_START) ||
                    ((state == WAIT_START) && ((opcode == OP_SPIKE) || (opcode == OP_RUN))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_evt && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dvs_ravens_receiver.sv
// -----------------------------------------------------------------------------
// tb_dvs_ravens_receiver
//   Directed scenarios followed by random packet traffic. A transaction-level
//   model (plain integers and queues) predicts the receiver; a monitor running
//   on the falling edge compares status outputs every cycle and pops expected
//   spikes whenever the DUT presents one.
// -----------------------------------------------------------------------------
module tb_dvs_ravens_receiver;

  localparam int SIM_TIME   = 15;
  localparam int FIFO_DEPTH = 4;
  localparam int PKT_BITS   = 11;
  localparam int TS_BITS    = $clog2(SIM_TIME + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  pkt_valid = 1'b0;
  logic [PKT_BITS-1:0]   ravens_pkt = '0;
  logic                  pkt_rdy;
  logic                  spike_valid;
  logic                  spike_rdy = 1'b1;
  logic [PKT_BITS-4:0]   spike_payload;
  logic [TS_BITS-1:0]    spike_timestep;
  logic                  sim_time_done;
  logic [TS_BITS-1:0]    timestep;
`ifdef DVS_RAVENS_RX_ERR_CNT_EN
  logic [7:0]            err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit rnd_rdy  = 0;

  // Reference model state
  int m_in_sim = 0;
  int m_ts     = 0;
  int m_done   = 0;
  int m_err    = 0;
  int q_pay[$];
  int q_ts[$];

  dvs_ravens_receiver #(
    .SIM_TIME(SIM_TIME), .FIFO_DEPTH(FIFO_DEPTH), .RAVENS_PKT_BITS(PKT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .ravens_pkt(ravens_pkt),
    .pkt_rdy(pkt_rdy), .spike_valid(spike_valid), .spike_rdy(spike_rdy),
    .spike_payload(spike_payload), .spike_timestep(spike_timestep),
    .sim_time_done(sim_time_done),
`ifdef DVS_RAVENS_RX_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .timestep(timestep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model, evaluated on the falling edge with inputs stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_pkt_rdy", int'(pkt_rdy), 1);
      chk("rst_spike_valid", int'(spike_valid), 0);
      chk("rst_spike_payload", int'(spike_payload), 0);
      chk("rst_spike_timestep", int'(spike_timestep), 0);
      chk("rst_sim_time_done", int'(sim_time_done), 0);
      chk("rst_timestep", int'(timestep), 0);
      m_in_sim = 0; m_ts = 0; m_done = 0; m_err = 0;
      q_pay.delete(); q_ts.delete();
    end else begin
      chk("pkt_rdy", int'(pkt_rdy), (q_pay.size() < FIFO_DEPTH) ? 1 : 0);
      chk("spike_valid", int'(spike_valid), (q_pay.size() > 0) ? 1 : 0);
      chk("timestep", int'(timestep), m_ts);
      chk("sim_time_done", int'(sim_time_done), m_done);
`ifdef DVS_RAVENS_RX_ERR_CNT_EN
      chk("err_cnt", int'(err_cnt), m_err);
`endif
      if (spike_valid && q_pay.size() > 0) begin
        chk("spike_payload", int'(spike_payload), q_pay[0]);
        chk("spike_timestep", int'(spike_timestep), q_ts[0]);
        if (spike_rdy) begin
          void'(q_pay.pop_front());
          void'(q_ts.pop_front());
        end
      end
      m_done = 0;
      if (pkt_valid && pkt_rdy) begin
        int op, p, n;
        op = int'(ravens_pkt[PKT_BITS-1 -: 3]);
        p  = int'(ravens_pkt[PKT_BITS-4:0]);
        if (op == 2) begin
          m_in_sim = 1; m_ts = 0;
        end else if (op == 0) begin
          if (m_in_sim == 1) begin
            q_pay.push_back(p); q_ts.push_back(m_ts);
          end else if (m_err < 255) m_err++;
        end else if (op == 1) begin
          if (m_in_sim == 1) begin
            n = (p == 0) ? 1 : p;
            if (m_ts + n >= SIM_TIME) begin
              m_ts = 0; m_in_sim = 0; m_done = 1;
            end else m_ts = m_ts + n;
          end else if (m_err < 255) m_err++;
        end else if (m_err < 255) m_err++;
      end
    end
  end

  // Random consumer back-pressure during the random phase.
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      spike_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one packet and hold it until accepted (bounded wait).
  task automatic send(input logic [2:0] op, input logic [7:0] p);
    bit acc = 0;
    pkt_valid  = 1'b1;
    ravens_pkt = {op, p};
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = pkt_rdy;
      @(posedge clk);
      #1;
    end
    pkt_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted op=%0d t=%0t", op, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Two spikes in the first timestep, drained in order.
    send(3'b010, 8'h00);
    send(3'b000, 8'h05);
    send(3'b000, 8'h09);
    idle(3);

    // RUN 3, spike, RUN 0 (=1), spike: tags 3 and 4, timestep 4.
    send(3'b010, 8'h00);
    send(3'b001, 8'd3);
    send(3'b000, 8'h11);
    send(3'b001, 8'd0);
    send(3'b000, 8'h12);
    idle(3);

    // Sim time completes on RUN 10 + RUN 7; next spike is dropped.
    send(3'b010, 8'h00);
    send(3'b001, 8'd10);
    send(3'b001, 8'd7);
    idle(2);
    send(3'b000, 8'h20);
    idle(3);

    // FIFO fill with consumer stalled, then drain.
    spike_rdy = 1'b0;
    send(3'b010, 8'h00);
    send(3'b000, 8'h41);
    send(3'b000, 8'h42);
    send(3'b000, 8'h43);
    send(3'b000, 8'h44);
    fork
      begin
        repeat (6) @(posedge clk);
        #1;
        spike_rdy = 1'b1;
      end
    join_none
    send(3'b000, 8'h45);
    idle(8);

    // Reset mid-sim with three entries buffered and timestep 6.
    send(3'b010, 8'h00);
    send(3'b001, 8'd6);
    spike_rdy = 1'b0;
    send(3'b000, 8'h51);
    send(3'b000, 8'h52);
    send(3'b000, 8'h53);
    idle(1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_spike_valid", int'(spike_valid), 0);
    chk("async_rst_timestep", int'(timestep), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    spike_rdy = 1'b1;
    send(3'b000, 8'h33);
    idle(3);

    // Random traffic with random back-pressure.
    rnd_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [2:0] op;
      logic [7:0] p;
      r = int'($urandom_range(0, 9));
      p = 8'($urandom);
      if (r < 5) op = 3'b000;
      else if (r < 7) begin
        op = 3'b001;
        if ($urandom_range(0, 15) != 0) p = 8'($urandom_range(0, 5));
      end
      else if (r == 7) op = 3'b010;
      else op = 3'($urandom_range(3, 7));
      send(op, p);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rnd_rdy = 0;
    @(posedge clk);
    #2;
    spike_rdy = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
